// File: rtl/iram_xfer_master_pkg.sv
// Shared types and constants for the internal-RAM burst transfer master.
package iram_xfer_master_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 8;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_WAIT = 3'd1,
        ST_WR_STB  = 3'd2,
        ST_RD_STB  = 3'd3,
        ST_RD_HOLD = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    // States in which one of the RAM strobes is driven low.
    function automatic logic is_strobe_state(input state_e s);
        return (s == ST_WR_STB) || (s == ST_RD_STB);
    endfunction

endpackage

// File: rtl/iram_xfer_master_if.sv
// Control, stream and RAM-port signals of the burst transfer master.
interface iram_xfer_master_if
    import iram_xfer_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) ();

    logic              start;
    logic              dir;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we_n;
    logic              mem_rd_n;

    modport master (
        input  start, dir, base_addr, len, abort,
        output busy, done, aborted,
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid,
        input  out_ready,
        output mem_addr, mem_wdata, mem_we_n, mem_rd_n,
        input  mem_rdata
    );

    modport slave (
        output start, dir, base_addr, len, abort,
        input  busy, done, aborted,
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready,
        input  mem_addr, mem_wdata, mem_we_n, mem_rd_n,
        output mem_rdata
    );

endinterface

// File: rtl/iram_xfer_addr_cnt.sv
// Burst address incrementer (wraps) and remaining-byte down-counter.
module iram_xfer_addr_cnt
    import iram_xfer_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_nxt_c,
    output logic              last_c
);

    localparam int unsigned REM_W = LEN_W + 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;

    // A zero length field stands for the full 2^LEN_W burst.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = base_i;
            rem_d  = (len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : REM_W'(len_i);
        end else if (step_i) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - REM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    // Next-cycle address lets the FSM register mem_addr on strobe entry.
    assign addr_nxt_c = addr_d;
    assign last_c     = (rem_q == REM_W'(1));

endmodule

// File: rtl/iram_xfer_master.sv
// Burst mover between a valid/ready byte stream and the 8051 internal RAM port.
module iram_xfer_master
    import iram_xfer_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    iram_xfer_master_if.master  bus
);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              mem_we_n_q, mem_we_n_d;
    logic              mem_rd_n_q, mem_rd_n_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              load_c;
    logic              step_c;
    logic [ADDR_W-1:0] addr_nxt_c;
    logic              last_c;

    iram_xfer_addr_cnt #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_c),
        .base_i     (bus.base_addr),
        .len_i      (bus.len),
        .step_i     (step_c),
        .addr_nxt_c (addr_nxt_c),
        .last_c     (last_c)
    );

    // Next-state logic; every output is derived from the next state so it registers cleanly.
    always_comb begin
        state_d     = state_q;
        load_c      = 1'b0;
        step_c      = 1'b0;
        aborted_d   = 1'b0;
        mem_wdata_d = mem_wdata_q;
        out_data_d  = out_data_q;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    state_d = (bus.dir == DIR_WR) ? ST_WR_WAIT : ST_RD_STB;
                end
            end
            ST_WR_WAIT: begin
                if (bus.in_valid && in_ready_q) begin
                    if (!bus.abort) begin
                        mem_wdata_d = bus.in_data;
                    end
                    state_d = ST_WR_STB;
                end
            end
            ST_WR_STB: begin
                step_c  = 1'b1;
                state_d = last_c ? ST_FIN : ST_WR_WAIT;
            end
            ST_RD_STB: begin
                out_data_d = bus.mem_rdata;
                state_d    = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                if (bus.out_ready) begin
                    step_c  = 1'b1;
                    state_d = last_c ? ST_FIN : ST_RD_STB;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any transition, including a same-cycle stream handshake.
        if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
            state_d   = ST_FIN;
            aborted_d = 1'b1;
        end

        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
        in_ready_d  = (state_d == ST_WR_WAIT);
        out_valid_d = (state_d == ST_RD_HOLD);
        mem_we_n_d  = (state_d != ST_WR_STB);
        mem_rd_n_d  = (state_d != ST_RD_STB);
        if (is_strobe_state(state_d)) begin
            mem_addr_d = addr_nxt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mem_we_n_q  <= 1'b1;
            mem_rd_n_q  <= 1'b1;
            out_data_q  <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mem_we_n_q  <= mem_we_n_d;
            mem_rd_n_q  <= mem_rd_n_d;
            out_data_q  <= out_data_d;
            mem_wdata_q <= mem_wdata_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.mem_we_n  = mem_we_n_q;
    assign bus.mem_rd_n  = mem_rd_n_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_iram_xfer_master.sv
// Directed bench for iram_xfer_master with a behavioural 256-byte RAM.
module tb_iram_xfer_master;
    import iram_xfer_master_pkg::*;

    logic clk;
    logic rst_n;

    iram_xfer_master_if bus ();

    iram_xfer_master dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [256];
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (bus.mem_we_n === 1'b0) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    int   we_cnt = 0;
    int   rd_cnt = 0;
    int   done_cnt = 0;
    int   overlap_cnt = 0;
    int   wide_cnt = 0;
    logic prev_we_n = 1'b1;
    logic prev_rd_n = 1'b1;

    // Strobe bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we_n === 1'b0) we_cnt++;
        if (bus.mem_rd_n === 1'b0) rd_cnt++;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.mem_we_n === 1'b0 && bus.mem_rd_n === 1'b0) overlap_cnt++;
        if ((bus.mem_we_n === 1'b0 && prev_we_n === 1'b0) ||
            (bus.mem_rd_n === 1'b0 && prev_rd_n === 1'b0)) wide_cnt++;
        prev_we_n = bus.mem_we_n;
        prev_rd_n = bus.mem_rd_n;
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] wr_bytes [256];
    logic [7:0] rd_got   [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic run_write(input logic [7:0] base, input logic [7:0] len_f, input int n,
                             input int abort_at, input int restart_at,
                             output bit got_done, output bit got_ab, output bit busy_first,
                             output bit busy_next, output bit strobe_before_done);
        int   idx = 0;
        int   we_seen = 0;
        int   cyc = 0;
        bit   hs;
        logic last_we_n = 1'b1;
        got_done = 0; got_ab = 0; busy_first = 0; busy_next = 1; strobe_before_done = 0;
        bus.start = 1'b1; bus.dir = DIR_WR; bus.base_addr = base; bus.len = len_f;
        bus.in_valid = 1'b1; bus.in_data = wr_bytes[0];
        while (cyc < 1200 && !got_done) begin
            hs = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            bus.start = (cyc == restart_at);
            if (cyc == restart_at) begin bus.dir = DIR_RD; bus.base_addr = 8'h00; end
            if (cyc == 1) busy_first = bus.busy;
            if (hs) idx++;
            bus.in_valid = (idx < n);
            bus.in_data  = (idx < n) ? wr_bytes[idx[7:0]] : 8'h00;
            bus.abort = 1'b0;
            if (bus.mem_we_n === 1'b0) begin
                we_seen++;
                if (we_seen == abort_at) bus.abort = 1'b1;
            end
            if (bus.done === 1'b1) begin
                got_done = 1;
                got_ab = bus.aborted;
                strobe_before_done = (last_we_n === 1'b0);
            end
            last_we_n = bus.mem_we_n;
        end
        bus.in_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        tick();
        busy_next = bus.busy;
    endtask

    task automatic run_read(input logic [7:0] base, input logic [7:0] len_f, input int stall,
                            output bit got_done, output bit got_ab, output int nrec,
                            output int stab_err, output bit busy_next);
        int         cyc = 0;
        int         total_valid = 0;
        bit         hs;
        bit         first = 1;
        logic [7:0] held = 8'h00;
        got_done = 0; got_ab = 0; nrec = 0; stab_err = 0; busy_next = 1;
        bus.start = 1'b1; bus.dir = DIR_RD; bus.base_addr = base; bus.len = len_f;
        bus.out_ready = 1'b0;
        while (cyc < 1200 && !got_done) begin
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                rd_got[nrec[7:0]] = bus.out_data;
                nrec++;
                first = 1;
            end
            tick();
            cyc++;
            bus.start = 1'b0;
            if (bus.out_valid === 1'b1) begin
                total_valid++;
                if (first) begin held = bus.out_data; first = 0; end
                else if (bus.out_data !== held) stab_err++;
            end
            bus.out_ready = (total_valid > stall);
            if (bus.done === 1'b1) begin got_done = 1; got_ab = bus.aborted; end
        end
        bus.out_ready = 1'b0;
        tick();
        busy_next = bus.busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.aborted !== 1'b0) begin failures++; $display("FAIL reset_aborted got=%b exp=0", bus.aborted); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.mem_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", bus.mem_we_n); end
        checks++; if (bus.mem_rd_n !== 1'b1) begin failures++; $display("FAIL reset_rd_n got=%b exp=1", bus.mem_rd_n); end
        checks++; if (bus.mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", bus.mem_wdata); end
        rst_n = 1'b1;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL idle_abort busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    endtask

    task automatic test_write_burst();
        bit d, ab, b1, bn, sb;
        int we0 = we_cnt;
        int dn0 = done_cnt;
        wr_bytes[0] = 8'hAA; wr_bytes[1] = 8'hBB; wr_bytes[2] = 8'hCC;
        run_write(8'h10, 8'd3, 3, 0, 0, d, ab, b1, bn, sb);
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL wr_busy_start got=%b exp=1", b1); end
        checks++; if (d !== 1'b1 || ab !== 1'b0) begin failures++; $display("FAIL wr_done done=%b aborted=%b exp=1/0", d, ab); end
        checks++; if (sb !== 1'b1) begin failures++; $display("FAIL wr_done_after_strobe got=%b exp=1", sb); end
        checks++; if (bn !== 1'b0) begin failures++; $display("FAIL wr_busy_after got=%b exp=0", bn); end
        checks++; if (we_cnt - we0 != 3) begin failures++; $display("FAIL wr_strobes got=%0d exp=3", we_cnt - we0); end
        checks++; if (done_cnt - dn0 != 1) begin failures++; $display("FAIL wr_done_pulses got=%0d exp=1", done_cnt - dn0); end
        checks++; if (ram[8'h10] !== 8'hAA || ram[8'h11] !== 8'hBB || ram[8'h12] !== 8'hCC) begin
            failures++; $display("FAIL wr_data got=%h %h %h exp=aa bb cc", ram[8'h10], ram[8'h11], ram[8'h12]); end
    endtask

    task automatic test_read_backpressure();
        bit d, ab, bn;
        int nrec, stab;
        int rd0 = rd_cnt;
        preload(8'h20, 8'h5A);
        preload(8'h21, 8'hA5);
        run_read(8'h20, 8'd2, 4, d, ab, nrec, stab, bn);
        checks++; if (d !== 1'b1 || ab !== 1'b0) begin failures++; $display("FAIL rd_done done=%b aborted=%b exp=1/0", d, ab); end
        checks++; if (nrec != 2) begin failures++; $display("FAIL rd_count got=%0d exp=2", nrec); end
        checks++; if (rd_got[0] !== 8'h5A || rd_got[1] !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h %h exp=5a a5", rd_got[0], rd_got[1]); end
        checks++; if (stab != 0) begin failures++; $display("FAIL rd_hold_stable got=%0d changes exp=0", stab); end
        checks++; if (rd_cnt - rd0 != 2) begin failures++; $display("FAIL rd_strobes got=%0d exp=2", rd_cnt - rd0); end
        checks++; if (bn !== 1'b0) begin failures++; $display("FAIL rd_busy_after got=%b exp=0", bn); end
    endtask

    task automatic test_wrap_len0();
        bit d, ab, b1, bn, sb;
        int we0 = we_cnt;
        for (int i = 0; i < 256; i++) wr_bytes[i] = 8'(i);
        run_write(8'hFF, 8'd0, 256, 0, 0, d, ab, b1, bn, sb);
        checks++; if (d !== 1'b1 || sb !== 1'b1) begin failures++; $display("FAIL wrap_done done=%b after_strobe=%b exp=1/1", d, sb); end
        checks++; if (we_cnt - we0 != 256) begin failures++; $display("FAIL wrap_strobes got=%0d exp=256", we_cnt - we0); end
        checks++; if (ram[8'hFF] !== 8'h00 || ram[8'h00] !== 8'h01) begin failures++; $display("FAIL wrap_edge got=%h %h exp=00 01", ram[8'hFF], ram[8'h00]); end
        checks++; if (ram[8'h7F] !== 8'h80 || ram[8'hFE] !== 8'hFF) begin failures++; $display("FAIL wrap_mid got=%h %h exp=80 ff", ram[8'h7F], ram[8'hFE]); end
    endtask

    task automatic test_abort();
        bit d, ab, b1, bn, sb;
        int we0;
        preload(8'h42, 8'hEE);
        we0 = we_cnt;
        wr_bytes[0] = 8'h11; wr_bytes[1] = 8'h22; wr_bytes[2] = 8'h33; wr_bytes[3] = 8'h44; wr_bytes[4] = 8'h55;
        run_write(8'h40, 8'd5, 5, 2, 0, d, ab, b1, bn, sb);
        checks++; if (d !== 1'b1 || ab !== 1'b1) begin failures++; $display("FAIL abort_done done=%b aborted=%b exp=1/1", d, ab); end
        checks++; if (we_cnt - we0 != 2) begin failures++; $display("FAIL abort_strobes got=%0d exp=2", we_cnt - we0); end
        checks++; if (ram[8'h40] !== 8'h11 || ram[8'h41] !== 8'h22 || ram[8'h42] !== 8'hEE) begin
            failures++; $display("FAIL abort_data got=%h %h %h exp=11 22 ee", ram[8'h40], ram[8'h41], ram[8'h42]); end
        checks++; if (bn !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%b exp=0", bn); end
        checks++; if (bus.aborted !== 1'b0) begin failures++; $display("FAIL abort_flag_clear got=%b exp=0", bus.aborted); end
    endtask

    task automatic test_start_while_busy();
        bit d, ab, b1, bn, sb;
        int rd0 = rd_cnt;
        int dn0 = done_cnt;
        wr_bytes[0] = 8'hC1; wr_bytes[1] = 8'hC2; wr_bytes[2] = 8'hC3; wr_bytes[3] = 8'hC4;
        run_write(8'h60, 8'd4, 4, 0, 3, d, ab, b1, bn, sb);
        checks++; if (d !== 1'b1 || ab !== 1'b0) begin failures++; $display("FAIL busy_start_done done=%b aborted=%b exp=1/0", d, ab); end
        checks++; if (rd_cnt - rd0 != 0 || done_cnt - dn0 != 1) begin failures++; $display("FAIL busy_start_ignored rd=%0d done=%0d exp=0/1", rd_cnt - rd0, done_cnt - dn0); end
        checks++; if (ram[8'h60] !== 8'hC1 || ram[8'h63] !== 8'hC4) begin failures++; $display("FAIL busy_start_data got=%h %h exp=c1 c4", ram[8'h60], ram[8'h63]); end
    endtask

    task automatic test_reset_mid_burst();
        bit d, ab, bn;
        int nrec, stab;
        int dn0;
        preload(8'h70, 8'h5C);
        dn0 = done_cnt;
        bus.start = 1'b1; bus.dir = DIR_WR; bus.base_addr = 8'h70; bus.len = 8'd4;
        bus.in_valid = 1'b1; bus.in_data = 8'h99;
        tick();
        bus.start = 1'b0;
        tick();
        checks++; if (bus.mem_we_n !== 1'b0) begin failures++; $display("FAIL rst_pre_strobe got=%b exp=0", bus.mem_we_n); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_we_n !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL rst_async we_n=%b busy=%b in_ready=%b exp=1/0/0", bus.mem_we_n, bus.busy, bus.in_ready); end
        checks++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
            failures++; $display("FAIL rst_async_bus addr=%h wdata=%h exp=00/00", bus.mem_addr, bus.mem_wdata); end
        bus.in_valid = 1'b0;
        tick(); tick();
        checks++; if (done_cnt != dn0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt - dn0); end
        checks++; if (ram[8'h70] !== 8'h5C) begin failures++; $display("FAIL rst_no_write got=%h exp=5c", ram[8'h70]); end
        rst_n = 1'b1;
        tick();
        run_read(8'h60, 8'd2, 0, d, ab, nrec, stab, bn);
        checks++; if (d !== 1'b1 || nrec != 2) begin failures++; $display("FAIL rst_restart done=%b bytes=%0d exp=1/2", d, nrec); end
        checks++; if (rd_got[0] !== 8'hC1 || rd_got[1] !== 8'hC2) begin failures++; $display("FAIL rst_restart_data got=%h %h exp=c1 c2", rd_got[0], rd_got[1]); end
    endtask

    task automatic test_strobe_rules();
        checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_cnt); end
        checks++; if (wide_cnt != 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", wide_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
        bus.start = 1'b0; bus.dir = DIR_WR; bus.base_addr = 8'h00; bus.len = 8'h00;
        bus.abort = 1'b0; bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_write_burst();
        test_read_backpressure();
        test_wrap_len0();
        test_abort();
        test_start_while_busy();
        test_reset_mid_burst();
        test_strobe_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
